// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio record/playback path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package audio_pkg;

    // Engine state, encoded as seen on the state output
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    // Widest channel sample the truncation helper handles
    localparam int MAX_CHAN_W = 32;

    // Keep the top out_w bits of a sample_w-bit channel (result right-aligned)
    function automatic logic [MAX_CHAN_W-1:0] trunc_chan(
        input logic [MAX_CHAN_W-1:0] sample,
        input int                    sample_w,
        input int                    out_w
    );
        return sample >> (sample_w - out_w);
    endfunction

endpackage

// File: rtl/audio_looper_ram.sv
// Simple dual-port frame buffer: one write port, one read port.
// Latency: read data registered, valid the cycle after raddr is presented.
// Backpressure: none; a write or read is accepted every cycle.
module audio_looper_ram #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port plus registered read; the array is never cleared
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/audio_looper.sv
// Mic-to-DAC record/playback engine with live passthrough and optional looping.
// Latency: 2 cycles from in_valid to out_valid in every state.
// Backpressure: none; in_valid is a strobe and also paces playback reads.
module audio_looper #(
    parameter int SAMPLE_W = 8,
    parameter int OUT_W    = 4,
    parameter int DEPTH    = 4096,
    parameter int CHANNELS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0] in_data,
    input  logic                         rec,
    input  logic                         play,
    input  logic                         loop_en,
    output logic                         out_valid,
    output logic [CHANNELS*OUT_W-1:0]    out_data,
    output logic [1:0]                   state,
    output logic [$clog2(DEPTH):0]       rec_len,
    output logic                         full
);

    import audio_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int FW = CHANNELS * SAMPLE_W;
    localparam int OW = CHANNELS * OUT_W;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   LEN_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LEN_FULL = (AW + 1)'(DEPTH);

    state_t        state_q;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          rec_d;
    logic          play_d;
    logic          rec_rise;
    logic          play_rise;
    logic          ram_we;
    logic          last_rd;
    logic [FW-1:0] ram_rdata;

    // First pipeline slot: valid, source select captured at issue, passthrough frame
    logic          s1_vld;
    logic          s1_from_ram;
    logic [FW-1:0] s1_pass;

    // Per-channel truncation of a full-width frame to the DAC width
    function automatic logic [OW-1:0] trunc_frame(input logic [FW-1:0] f);
        logic [OW-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            r[c*OUT_W +: OUT_W] = OUT_W'(trunc_chan(MAX_CHAN_W'(f[c*SAMPLE_W +: SAMPLE_W]),
                                                    SAMPLE_W, OUT_W));
        end
        return r;
    endfunction

    assign rec_rise  = rec  & ~rec_d;
    assign play_rise = play & ~play_d;
    assign ram_we    = (state_q == ST_RECORD) && in_valid;
    assign last_rd   = ({1'b0, rptr} == (rec_len - LEN_ONE));
    assign state     = state_q;

    audio_looper_ram #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wptr),
        .wdata (in_data),
        .raddr (rptr),
        .rdata (ram_rdata)
    );

    // Level history for rec/play edge detection; zero so a level held through reset is an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_d  <= 1'b0;
            play_d <= 1'b0;
        end else begin
            rec_d  <= rec;
            play_d <= play;
        end
    end

    // Record/play state machine with pointers, recorded length and full flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wptr    <= '0;
            rptr    <= '0;
            rec_len <= '0;
            full    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rec_rise) begin
                        state_q <= ST_RECORD;
                        wptr    <= '0;
                        full    <= 1'b0;
                    end else if (play_rise && (rec_len != '0)) begin
                        state_q <= ST_PLAY;
                        rptr    <= '0;
                    end
                end
                ST_RECORD: begin
                    if (in_valid) begin
                        wptr <= wptr + PTR_ONE;
                    end
                    // A frame arriving in the exit cycle is still counted
                    if (in_valid && (wptr == PTR_LAST)) begin
                        state_q <= ST_IDLE;
                        rec_len <= LEN_FULL;
                        full    <= 1'b1;
                    end else if (!rec) begin
                        state_q <= ST_IDLE;
                        rec_len <= in_valid ? ({1'b0, wptr} + LEN_ONE) : {1'b0, wptr};
                    end
                end
                ST_PLAY: begin
                    if (in_valid) begin
                        if (last_rd) begin
                            rptr <= '0;
                            if (!loop_en) begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            rptr <= rptr + PTR_ONE;
                        end
                    end
                    if (!play) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-stage output pipeline; the source is fixed by the state when the frame was issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld      <= 1'b0;
            s1_from_ram <= 1'b0;
            s1_pass     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_from_ram <= (state_q == ST_PLAY);
                s1_pass     <= in_data;
            end
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_data <= trunc_frame(s1_from_ram ? ram_rdata : s1_pass);
            end
        end
    end

endmodule
